irq_controller: RTL and testbench

Memory-mapped interrupt controller directly upstream of the pipelined core's interrupt inputs. Synchronises up to `N_SRC` external request lines, latches them as edge- or level-triggered pending bits, and applies per-source enable and 3-bit priority. It presents the winning level on the core's active-low `OINT_n[2:0]` and retires the request on the core's `IACK_n` acknowledge. Configuration and status registers sit on the core's data bus (`DAD`/`MREQ`/`WRITE`/`SIZE`); this block answers with its own `ack_n`.

---
 rtl/irq_controller_pkg.sv | 29 ++
 rtl/irq_controller_if.sv | 13 +
 rtl/irq_sync_edge.sv | 39 +++
 rtl/irq_controller.sv | 198 +++++++++++++++++++
 tb/tb_irq_controller.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, access size,
// FSM state types and a mask helper.
package irq_controller_pkg;

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_EDGE    = 3'd2;
  localparam logic [2:0] OFF_PRIO    = 3'd3;
  localparam logic [2:0] OFF_LAST_ID = 3'd4;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [2:0] OINT_NONE = 3'b111;

  typedef enum logic {
    B_IDLE,
    B_ACK
  } bus_state_t;

  typedef enum logic [1:0] {
    I_IDLE,
    I_REQ,
    I_ACKED
  } irq_state_t;

  function automatic logic [31:0] low_mask(input int unsigned width);
    return 32'((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Data-bus slave port of the interrupt controller (core side is the master).
interface irq_controller_if;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack_n;

  modport master (output DAD, MREQ, WRITE, SIZE, wdata, input rdata, ack_n);
  modport slave  (input DAD, MREQ, WRITE, SIZE, wdata, output rdata, ack_n);
endinterface

// File: rtl/irq_sync_edge.sv
// One request source: 2-flop synchroniser plus edge- or level-mode pending bit.
module irq_sync_edge (
  input  logic clk,
  input  logic reset_x,
  input  logic irq,
  input  logic edge_mode,
  input  logic clr,
  input  logic w1c,
  output logic pending
);

  logic sync_a;
  logic sync_b;
  logic sync_d;
  logic rise;

  assign rise = sync_b & ~sync_d;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      sync_d  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_a <= irq;
      sync_b <= sync_a;
      sync_d <= sync_b;
      // Clears only touch edge sources, and a fresh edge beats any clear.
      if (!edge_mode)
        pending <= sync_b;
      else if (rise)
        pending <= 1'b1;
      else if (clr || w1c)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: per-source pending/enable/priority, a
// priority tree, a register bus FSM and the core-facing request FSM.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int unsigned N_SRC     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic [N_SRC-1:0] irq_in,
  irq_controller_if.slave  bus,
  output logic [2:0]       OINT_n,
  input  logic             IACK_n
);

  localparam logic [31:0] SRC_MASK  = low_mask(N_SRC);
  localparam logic [31:0] PRIO_MASK = low_mask(3 * N_SRC);

  logic [31:0] enable_r;
  logic [31:0] edge_mode_r;
  logic [31:0] prio_r;
  logic        last_valid;
  logic [3:0]  last_id;
  logic [31:0] rdata_q;

  bus_state_t  bstate, bstate_n;
  irq_state_t  istate, istate_n;
  logic [3:0]  cur_id, cur_id_n;
  logic [2:0]  cur_lvl, cur_lvl_n;
  logic        ack_fire;

  logic             hit;
  logic             word;
  logic             wr_commit;
  logic [2:0]       offset;
  logic [31:0]      read_val;
  logic [N_SRC-1:0] w1c_vec;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] cand;
  logic [15:0]      cand16;
  logic             any_cand;
  logic             cur_still;
  logic [2:0]       win_lvl;
  logic [3:0]       win_id;
  logic             unused_addr;

  assign hit         = bus.MREQ && (bus.DAD[31:5] == BASE_ADDR[31:5]);
  assign offset      = bus.DAD[4:2];
  assign word        = (bus.SIZE == SIZE_WORD);
  assign wr_commit   = (bstate == B_IDLE) && hit && bus.WRITE && word;
  assign w1c_vec     = (wr_commit && offset == OFF_PENDING) ? bus.wdata[N_SRC-1:0] : '0;
  assign unused_addr = ^bus.DAD[1:0];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge u_sync (
      .clk       (clk),
      .reset_x   (reset_x),
      .irq       (irq_in[g]),
      .edge_mode (edge_mode_r[g]),
      .clr       (ack_fire && (cur_id == 4'(g))),
      .w1c       (w1c_vec[g]),
      .pending   (pending[g])
    );
  end

  always_comb begin
    read_val = '0;
    case (offset)
      OFF_PENDING: read_val = 32'(pending);
      OFF_ENABLE:  read_val = enable_r;
      OFF_EDGE:    read_val = edge_mode_r;
      OFF_PRIO:    read_val = prio_r;
      OFF_LAST_ID: read_val = {last_valid, 27'd0, last_id};
      default:     read_val = '0;
    endcase
  end

  // Bus FSM: state register, next state, outputs.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      bstate      <= B_IDLE;
      rdata_q     <= '0;
      enable_r    <= '0;
      edge_mode_r <= '0;
      prio_r      <= '0;
    end else begin
      bstate <= bstate_n;
      if (bstate == B_IDLE && hit)
        rdata_q <= read_val;
      if (wr_commit) begin
        case (offset)
          OFF_ENABLE: enable_r    <= bus.wdata & SRC_MASK;
          OFF_EDGE:   edge_mode_r <= bus.wdata & SRC_MASK;
          OFF_PRIO:   prio_r      <= bus.wdata & PRIO_MASK;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    bstate_n = B_IDLE;
    if (bstate == B_IDLE && hit)
      bstate_n = B_ACK;
  end

  always_comb begin
    bus.ack_n = (bstate != B_ACK);
    bus.rdata = (bstate == B_ACK) ? rdata_q : '0;
  end

  // Priority tree: strict '>' keeps the lowest index on equal priority.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < N_SRC; i++)
      cand[i] = pending[i] && enable_r[i] && (prio_r[3*i +: 3] != 3'd0);
  end

  always_comb begin
    win_lvl = '0;
    win_id  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (cand[i] && (prio_r[3*i +: 3] > win_lvl)) begin
        win_lvl = prio_r[3*i +: 3];
        win_id  = 4'(i);
      end
    end
  end

  assign cand16    = 16'(cand);
  assign any_cand  = |cand;
  assign cur_still = cand16[cur_id];

  // IRQ FSM: state register, next state, outputs.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      istate     <= I_IDLE;
      cur_id     <= '0;
      cur_lvl    <= '0;
      last_valid <= 1'b0;
      last_id    <= '0;
    end else begin
      istate  <= istate_n;
      cur_id  <= cur_id_n;
      cur_lvl <= cur_lvl_n;
      if (ack_fire) begin
        last_valid <= 1'b1;
        last_id    <= cur_id;
      end
    end
  end

  // An acknowledge outranks a same-cycle preemption, so it retires the id the core saw.
  always_comb begin
    istate_n  = istate;
    cur_id_n  = cur_id;
    cur_lvl_n = cur_lvl;
    ack_fire  = 1'b0;
    case (istate)
      I_IDLE: begin
        if (any_cand) begin
          istate_n  = I_REQ;
          cur_id_n  = win_id;
          cur_lvl_n = win_lvl;
        end
      end
      I_REQ: begin
        if (!IACK_n) begin
          istate_n = I_ACKED;
          ack_fire = 1'b1;
        end else if (!cur_still) begin
          if (any_cand) begin
            cur_id_n  = win_id;
            cur_lvl_n = win_lvl;
          end else begin
            istate_n = I_IDLE;
          end
        end else if (win_lvl > cur_lvl) begin
          cur_id_n  = win_id;
          cur_lvl_n = win_lvl;
        end
      end
      I_ACKED: begin
        if (IACK_n)
          istate_n = I_IDLE;
      end
      default: istate_n = I_IDLE;
    endcase
  end

  always_comb begin
    OINT_n = OINT_NONE;
    if (istate == I_REQ)
      OINT_n = ~cur_lvl;
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized
// edge-source rounds checked against a priority-rule reference model.
module tb_irq_controller;

  localparam int unsigned NS   = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          reset_x = 1'b0;
  logic [NS-1:0] irq_in = '0;
  logic          IACK_n = 1'b1;
  logic [2:0]    OINT_n;

  irq_controller_if bus ();

  irq_controller #(.N_SRC(NS), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .reset_x (reset_x),
    .irq_in  (irq_in),
    .bus     (bus),
    .OINT_n  (OINT_n),
    .IACK_n  (IACK_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [NS-1:0] m_enable;
  logic [NS-1:0] m_pending;
  logic [2:0]    m_prio [NS];
  logic          m_last_valid;
  logic [3:0]    m_last_id;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_access(input logic [4:0] off, input logic wr, input logic [1:0] size,
                            input logic [31:0] data, output logic ack, output logic [31:0] rd);
    bus.DAD   = BASE | 32'(off);
    bus.MREQ  = 1'b1;
    bus.WRITE = wr;
    bus.SIZE  = size;
    bus.wdata = data;
    tick();
    ack = bus.ack_n;
    rd  = bus.rdata;
    bus.MREQ  = 1'b0;
    bus.WRITE = 1'b0;
    tick();
  endtask

  task automatic reg_write(input logic [4:0] off, input logic [31:0] data);
    logic a;
    logic [31:0] r;
    bus_access(off, 1'b1, 2'b10, data, a, r);
  endtask

  task automatic reg_read(input logic [4:0] off, output logic [31:0] data);
    logic a;
    bus_access(off, 1'b0, 2'b10, 32'd0, a, data);
  endtask

  task automatic do_reset();
    reset_x  = 1'b0;
    irq_in   = '0;
    IACK_n   = 1'b1;
    bus.MREQ = 1'b0;
    tick();
    tick();
    reset_x = 1'b1;
    tick();
  endtask

  // Reference: scan levels from 7 down, first enabled pending source at that level wins.
  task automatic model_pick(output logic any, output logic [2:0] lvl, output logic [3:0] id);
    any = 1'b0;
    lvl = 3'd0;
    id  = 4'd0;
    for (int l = 7; l >= 1; l--) begin
      for (int i = 0; i < NS; i++) begin
        if (!any && m_enable[i] && m_pending[i] && (int'(m_prio[i]) == l)) begin
          any = 1'b1;
          lvl = 3'(l);
          id  = 4'(i);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_x = 1'b0;
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL reset_oint: got %b expected 111", OINT_n); end
    n_checks++;
    if (bus.ack_n !== 1'b1) begin n_errors++; $display("FAIL reset_ack: got %b expected 1", bus.ack_n); end
    n_checks++;
    if (bus.rdata !== 32'd0) begin n_errors++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    reset_x = 1'b1;
    tick();
    for (int o = 0; o < 8; o++) begin
      reg_read(5'(o * 4), r);
      n_checks++;
      if (r !== 32'd0) begin n_errors++; $display("FAIL reset_reg_%0d: got %h expected 0", o * 4, r); end
    end
  endtask

  task automatic test_single_edge();
    logic [31:0] r;
    do_reset();
    reg_write(5'h04, 32'h1);
    reg_write(5'h08, 32'h1);
    reg_write(5'h0C, 32'h5);
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    tick();
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL edge_early: got %b expected 111", OINT_n); end
    tick();
    n_checks++;
    if (OINT_n !== 3'b010) begin n_errors++; $display("FAIL edge_latency: got %b expected 010", OINT_n); end
    IACK_n = 1'b0;
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL edge_iack: got %b expected 111", OINT_n); end
    IACK_n = 1'b1;
    tick();
    reg_read(5'h00, r);
    n_checks++;
    if (r !== 32'd0) begin n_errors++; $display("FAIL edge_pending: got %h expected 0", r); end
    reg_read(5'h10, r);
    n_checks++;
    if (r !== 32'h8000_0000) begin n_errors++; $display("FAIL edge_last_id: got %h expected 80000000", r); end
  endtask

  task automatic test_preempt();
    logic [31:0] r;
    do_reset();
    reg_write(5'h04, 32'h12);
    reg_write(5'h08, 32'h12);
    reg_write(5'h0C, (32'd3 << 3) | (32'd6 << 12));
    irq_in[1] = 1'b1;
    tick();
    irq_in[1] = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (OINT_n !== 3'b100) begin n_errors++; $display("FAIL preempt_low: got %b expected 100", OINT_n); end
    irq_in[4] = 1'b1;
    tick();
    irq_in[4] = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (OINT_n !== 3'b001) begin n_errors++; $display("FAIL preempt_high: got %b expected 001", OINT_n); end
    IACK_n = 1'b0;
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL preempt_iack: got %b expected 111", OINT_n); end
    IACK_n = 1'b1;
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL preempt_release: got %b expected 111", OINT_n); end
    tick();
    n_checks++;
    if (OINT_n !== 3'b100) begin n_errors++; $display("FAIL preempt_rereq: got %b expected 100", OINT_n); end
    reg_read(5'h10, r);
    n_checks++;
    if (r !== 32'h8000_0004) begin n_errors++; $display("FAIL preempt_last_id: got %h expected 80000004", r); end
    reg_read(5'h00, r);
    n_checks++;
    if (r !== 32'h2) begin n_errors++; $display("FAIL preempt_pending: got %h expected 2", r); end
  endtask

  task automatic test_level();
    logic [31:0] r;
    do_reset();
    reg_write(5'h04, 32'h04);
    reg_write(5'h0C, 32'd7 << 6);
    irq_in[2] = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (OINT_n !== 3'b000) begin n_errors++; $display("FAIL level_req: got %b expected 000", OINT_n); end
    IACK_n = 1'b0;
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL level_iack: got %b expected 111", OINT_n); end
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL level_hold: got %b expected 111", OINT_n); end
    IACK_n = 1'b1;
    tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL level_release: got %b expected 111", OINT_n); end
    tick();
    n_checks++;
    if (OINT_n !== 3'b000) begin n_errors++; $display("FAIL level_rereq: got %b expected 000", OINT_n); end
    reg_write(5'h00, 32'h04);
    reg_read(5'h00, r);
    n_checks++;
    if (r !== 32'h04) begin n_errors++; $display("FAIL level_w1c: got %h expected 4", r); end
    irq_in[2] = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL level_drop: got %b expected 111", OINT_n); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] r;
    do_reset();
    reg_write(5'h08, 32'h01);
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    repeat (4) tick();
    reg_read(5'h00, r);
    n_checks++;
    if (r !== 32'h1) begin n_errors++; $display("FAIL w1c_setup: got %h expected 1", r); end
    // New rising edge timed so its detect cycle ends on the W1C commit edge.
    irq_in[0] = 1'b1;
    tick();
    tick();
    bus.DAD   = BASE;
    bus.MREQ  = 1'b1;
    bus.WRITE = 1'b1;
    bus.SIZE  = 2'b10;
    bus.wdata = 32'h1;
    tick();
    bus.MREQ  = 1'b0;
    bus.WRITE = 1'b0;
    tick();
    irq_in[0] = 1'b0;
    reg_read(5'h00, r);
    n_checks++;
    if (r !== 32'h1) begin n_errors++; $display("FAIL w1c_race: got %h expected 1", r); end
    repeat (3) tick();
    reg_write(5'h00, 32'h1);
    reg_read(5'h00, r);
    n_checks++;
    if (r !== 32'h0) begin n_errors++; $display("FAIL w1c_clear: got %h expected 0", r); end
  endtask

  task automatic test_bus();
    logic        a;
    logic [31:0] r;
    logic [3:0]  acks;
    do_reset();
    bus.DAD   = BASE | 32'h4;
    bus.MREQ  = 1'b1;
    bus.WRITE = 1'b1;
    bus.SIZE  = 2'b10;
    bus.wdata = 32'hA5;
    tick();
    acks[0] = bus.ack_n;
    bus.DAD   = BASE | 32'hC;
    bus.wdata = 32'h1234;
    tick();
    acks[1] = bus.ack_n;
    tick();
    acks[2] = bus.ack_n;
    bus.MREQ  = 1'b0;
    bus.WRITE = 1'b0;
    tick();
    acks[3] = bus.ack_n;
    n_checks++;
    if (acks !== 4'b1010) begin n_errors++; $display("FAIL bus_b2b_ack: got %b expected 1010", acks); end
    reg_read(5'h04, r);
    n_checks++;
    if (r !== 32'hA5) begin n_errors++; $display("FAIL bus_rd_enable: got %h expected a5", r); end
    reg_read(5'h0C, r);
    n_checks++;
    if (r !== 32'h1234) begin n_errors++; $display("FAIL bus_rd_prio: got %h expected 1234", r); end
    bus_access(5'h04, 1'b1, 2'b00, 32'hFF, a, r);
    n_checks++;
    if (a !== 1'b0) begin n_errors++; $display("FAIL bus_byte_ack: got %b expected 0", a); end
    bus_access(5'h04, 1'b0, 2'b00, 32'h0, a, r);
    n_checks++;
    if (r !== 32'hA5) begin n_errors++; $display("FAIL bus_byte_keep: got %h expected a5", r); end
    reg_read(5'h14, r);
    n_checks++;
    if (r !== 32'h0) begin n_errors++; $display("FAIL bus_rd_14: got %h expected 0", r); end
    reg_write(5'h18, 32'hFFFF_FFFF);
    reg_read(5'h18, r);
    n_checks++;
    if (r !== 32'h0) begin n_errors++; $display("FAIL bus_rd_18: got %h expected 0", r); end
    reg_write(5'h08, 32'hFFFF_FFFF);
    reg_read(5'h08, r);
    n_checks++;
    if (r !== 32'hFF) begin n_errors++; $display("FAIL bus_mask_edge: got %h expected ff", r); end
    bus.DAD  = BASE + 32'h20;
    bus.MREQ = 1'b1;
    tick();
    a = bus.ack_n;
    r = bus.rdata;
    bus.MREQ = 1'b0;
    tick();
    n_checks++;
    if ({a, r} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL bus_outside: got ack %b rdata %h expected 1/0", a, r); end
  endtask

  task automatic test_random();
    logic          any;
    logic [2:0]    lvl;
    logic [3:0]    id;
    logic [31:0]   r;
    logic [31:0]   prio_word;
    logic [NS-1:0] pulses;
    do_reset();
    reg_write(5'h08, 32'hFF);
    m_last_valid = 1'b0;
    m_last_id    = 4'd0;
    for (int it = 0; it < 24; it++) begin
      m_enable  = NS'($urandom);
      prio_word = '0;
      for (int i = 0; i < NS; i++) begin
        m_prio[i] = 3'($urandom_range(0, 7));
        prio_word[3*i +: 3] = m_prio[i];
      end
      reg_write(5'h04, 32'(m_enable));
      reg_write(5'h0C, prio_word);
      pulses = NS'($urandom);
      irq_in = pulses;
      tick();
      irq_in = '0;
      repeat (5) tick();
      m_pending = pulses;
      model_pick(any, lvl, id);
      n_checks++;
      if (OINT_n !== (any ? ~lvl : 3'b111)) begin
        n_errors++;
        $display("FAIL rand_oint[%0d]: got %b expected %b", it, OINT_n, any ? ~lvl : 3'b111);
      end
      if (any) begin
        IACK_n = 1'b0;
        tick();
        IACK_n = 1'b1;
        tick();
        m_pending[id] = 1'b0;
        m_last_valid  = 1'b1;
        m_last_id     = id;
      end
      reg_read(5'h00, r);
      n_checks++;
      if (r !== 32'(m_pending)) begin n_errors++; $display("FAIL rand_pending[%0d]: got %h expected %h", it, r, 32'(m_pending)); end
      reg_read(5'h10, r);
      n_checks++;
      if (r !== {m_last_valid, 27'd0, m_last_id}) begin
        n_errors++;
        $display("FAIL rand_last_id[%0d]: got %h expected %h", it, r, {m_last_valid, 27'd0, m_last_id});
      end
      reg_write(5'h00, 32'hFF);
      repeat (4) tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    do_reset();
    reg_write(5'h04, 32'h1);
    reg_write(5'h08, 32'h1);
    reg_write(5'h0C, 32'h5);
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (OINT_n !== 3'b010) begin n_errors++; $display("FAIL rstmid_pre: got %b expected 010", OINT_n); end
    bus.DAD   = BASE | 32'h4;
    bus.MREQ  = 1'b1;
    bus.WRITE = 1'b0;
    bus.SIZE  = 2'b10;
    tick();
    n_checks++;
    if ({bus.ack_n, bus.rdata} !== {1'b0, 32'h1}) begin
      n_errors++;
      $display("FAIL rstmid_read: got ack %b rdata %h expected 0/1", bus.ack_n, bus.rdata);
    end
    #2;
    reset_x = 1'b0;
    #1;
    n_checks++;
    if ({OINT_n, bus.ack_n, bus.rdata} !== {3'b111, 1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL rstmid_async: got oint %b ack %b rdata %h expected 111/1/0", OINT_n, bus.ack_n, bus.rdata);
    end
    bus.MREQ = 1'b0;
    tick();
    reset_x = 1'b1;
    tick();
    for (int o = 0; o < 5; o++) begin
      reg_read(5'(o * 4), r);
      n_checks++;
      if (r !== 32'd0) begin n_errors++; $display("FAIL rstmid_reg_%0d: got %h expected 0", o * 4, r); end
    end
    n_checks++;
    if (OINT_n !== 3'b111) begin n_errors++; $display("FAIL rstmid_post: got %b expected 111", OINT_n); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DAD   = '0;
    bus.MREQ  = 1'b0;
    bus.WRITE = 1'b0;
    bus.SIZE  = 2'b10;
    bus.wdata = '0;
    #1;
    test_reset();
    test_single_edge();
    test_preempt();
    test_level();
    test_w1c_race();
    test_bus();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
